// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the UART program loader.
//                Holds the loader frame-parser state enum, the UART receiver
//                state enum, the frame sync byte and the address width.
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         ADDR_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_H = 3'd1,
        ST_ADDR_L = 3'd2,
        ST_LEN_H  = 3'd3,
        ST_LEN_L  = 3'd4,
        ST_DATA   = 3'd5,
        ST_CSUM   = 3'd6
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver operating on an already-synchronised line.
//                A falling edge while idle starts a frame; the start bit is
//                re-checked half a bit later and dropped if high (glitch).
//                Data bits are sampled LSB first at mid-bit, then the stop bit.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                rx_sync         - synchronised receive line (idle high)
//                byte_valid      - 1-cycle strobe, rx_byte holds the byte
//                rx_byte[7:0]    - received byte
//                frame_err       - 1-cycle strobe instead of byte_valid when
//                                  the stop bit is sampled low
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_rx_prev  <= 1'b1;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            r_rx_prev  <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_prev && !rx_sync) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // A start bit that has already returned high was a glitch.
                        r_state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt     <= '0;
                        r_shift   <= {rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= r_shift;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule : uart_rx
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader
//  Description : Serial program loader. Receives a framed image over 8N1 UART
//                (A5, addr_hi, addr_lo, len_hi, len_lo, data..., checksum) and
//                writes it byte-by-byte into on-chip RAM while holding the CPU.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                rx              - asynchronous UART line, idle high
//                address[15:0]   - memory write address
//                data_out[7:0]   - memory write data
//                wrt_en          - 1-cycle write strobe
//                chip_select     - asserted together with wrt_en
//                cpu_hold        - high while a frame is in progress
//                load_done       - 1-cycle pulse on good checksum
//                error           - sticky checksum/framing/timeout flag
//  Revision    : 1.0  initial release
// ============================================================================
module uart_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        data_out,
    output logic              wrt_en,
    output logic              chip_select,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              error
);

    localparam int c_TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT = c_TIMER_W'(TIMEOUT_CYCLES);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_byte_valid;
    logic [7:0]           w_byte;
    logic                 w_frame_err;
    logic                 w_timeout;

    loader_state_t        r_state;
    logic [ADDR_W-1:0]    r_ptr;
    logic [15:0]          r_count;
    logic [7:0]           r_sum;
    logic [c_TIMER_W-1:0] r_timer;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_sync    (r_sync2),
        .byte_valid (w_byte_valid),
        .rx_byte    (w_byte),
        .frame_err  (w_frame_err)
    );

    assign w_timeout = (r_timer >= c_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_timer     <= '0;
            address     <= '0;
            data_out    <= '0;
            wrt_en      <= 1'b0;
            chip_select <= 1'b0;
            cpu_hold    <= 1'b0;
            load_done   <= 1'b0;
            error       <= 1'b0;
        end else begin
            wrt_en      <= 1'b0;
            chip_select <= 1'b0;
            load_done   <= 1'b0;

            // Inter-byte idle timer only runs inside a frame.
            if (r_state == ST_IDLE || w_byte_valid) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (r_state == ST_IDLE) begin
                // Framing errors while idle are line noise, not load errors.
                if (w_byte_valid && w_byte == SYNC_BYTE) begin
                    r_state  <= ST_ADDR_H;
                    error    <= 1'b0;
                    cpu_hold <= 1'b1;
                    r_sum    <= '0;
                end
            end else if (w_frame_err || w_timeout) begin
                r_state  <= ST_IDLE;
                error    <= 1'b1;
                cpu_hold <= 1'b0;
            end else if (w_byte_valid) begin
                case (r_state)
                    ST_ADDR_H: begin
                        r_ptr[15:8] <= w_byte;
                        r_state     <= ST_ADDR_L;
                    end
                    ST_ADDR_L: begin
                        r_ptr[7:0] <= w_byte;
                        r_state    <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        r_count[15:8] <= w_byte;
                        r_state       <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        r_count[7:0] <= w_byte;
                        r_state      <= ({r_count[15:8], w_byte} != 16'd0) ? ST_DATA : ST_CSUM;
                    end
                    ST_DATA: begin
                        address     <= r_ptr;
                        data_out    <= w_byte;
                        wrt_en      <= 1'b1;
                        chip_select <= 1'b1;
                        r_ptr       <= r_ptr + 1'b1;
                        r_sum       <= r_sum + w_byte;
                        r_count     <= r_count - 16'd1;
                        if (r_count == 16'd1) begin
                            r_state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (w_byte == r_sum) begin
                            load_done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        cpu_hold <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule : uart_loader
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_loader
//  Description : Directed self-checking bench for uart_loader. Frames are
//                serialised onto rx bit by bit; a negedge monitor logs every
//                memory write and load_done pulse for the scenario tasks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_loader;

    localparam int CPB = 16;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        wrt_en;
    logic        chip_select;
    logic        cpu_hold;
    logic        load_done;
    logic        error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_loader #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .address     (address),
        .data_out    (data_out),
        .wrt_en      (wrt_en),
        .chip_select (chip_select),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .error       (error)
    );

    // Write/strobe monitor
    logic [23:0] wq[$];
    int          done_cnt = 0;
    int          wide_cnt = 0;
    int          cs_bad = 0;
    logic        hold_at_done = 1'b1;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (wrt_en === 1'b1) wq.push_back({address, data_out});
        if (wrt_en === 1'b1 && prev_we === 1'b1) wide_cnt++;
        if (wrt_en !== chip_select) cs_bad++;
        if (load_done === 1'b1) begin
            done_cnt++;
            hold_at_done = cpu_hold;
        end
        prev_we = wrt_en;
    end

    logic [7:0]  tx_q[$];
    logic [23:0] exp_w[$];

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_q(input int bad_idx);
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], (i != bad_idx));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (address !== 16'h0) begin errors++; $display("FAIL reset_address got=%h exp=0000", address); end
        checks++; if (data_out !== 8'h0) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if ({wrt_en, chip_select, cpu_hold, load_done, error} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {wrt_en, chip_select, cpu_hold, load_done, error}); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic;
        int w0 = wq.size();
        int d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_after_sync got=%b exp=1", cpu_hold); end
        tx_q  = {8'h02, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        exp_w = {24'h0200_11, 24'h0201_22, 24'h0202_33};
        send_q(-1);
        @(negedge clk);
        checks++; if (wq.size() - w0 !== 3) begin errors++; $display("FAIL basic_write_count got=%0d exp=3", wq.size() - w0); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= wq.size() || wq[w0 + i] !== exp_w[i]) begin
                errors++; $display("FAIL basic_write%0d got=%h exp=%h", i, (w0 + i < wq.size()) ? wq[w0 + i] : 24'hx, exp_w[i]);
            end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_load_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got=%b exp=0", error); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_hold_end got=%b exp=0", cpu_hold); end
        checks++; if (hold_at_done !== 1'b0) begin errors++; $display("FAIL basic_hold_at_done got=%b exp=0", hold_at_done); end
    endtask

    task automatic test_bad_csum;
        int w0 = wq.size();
        int d0 = done_cnt;
        tx_q  = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        exp_w = {24'h0200_11, 24'h0201_22, 24'h0202_33};
        send_q(-1);
        @(negedge clk);
        checks++; if (wq.size() - w0 !== 3) begin errors++; $display("FAIL csum_write_count got=%0d exp=3", wq.size() - w0); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= wq.size() || wq[w0 + i] !== exp_w[i]) begin
                errors++; $display("FAIL csum_write%0d got=%h exp=%h", i, (w0 + i < wq.size()) ? wq[w0 + i] : 24'hx, exp_w[i]);
            end
        end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL csum_load_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL csum_error got=%b exp=1", error); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL csum_hold got=%b exp=0", cpu_hold); end
    endtask

    task automatic test_wrap;
        int w0 = wq.size();
        int d0 = done_cnt;
        tx_q  = {8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h65};
        exp_w = {24'hFFFF_AA, 24'h0000_BB};
        send_q(-1);
        @(negedge clk);
        checks++; if (wq.size() - w0 !== 2) begin errors++; $display("FAIL wrap_write_count got=%0d exp=2", wq.size() - w0); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= wq.size() || wq[w0 + i] !== exp_w[i]) begin
                errors++; $display("FAIL wrap_write%0d got=%h exp=%h", i, (w0 + i < wq.size()) ? wq[w0 + i] : 24'hx, exp_w[i]);
            end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wrap_load_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL wrap_error_cleared got=%b exp=0", error); end
    endtask

    task automatic test_zero_len;
        int w0 = wq.size();
        int d0 = done_cnt;
        tx_q = {8'h00, 8'h5A};
        send_q(-1);
        @(negedge clk);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_junk_hold got=%b exp=0", cpu_hold); end
        tx_q = {8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        send_q(-1);
        @(negedge clk);
        checks++; if (wq.size() - w0 !== 0) begin errors++; $display("FAIL zero_write_count got=%0d exp=0", wq.size() - w0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_load_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL zero_error got=%b exp=0", error); end
    endtask

    task automatic test_frame_err;
        int w0 = wq.size();
        int d0 = done_cnt;
        // Byte index 6 is the second data byte; its stop bit is forced low.
        tx_q = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h04, 8'h01, 8'h02};
        send_q(6);
        @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ferr_error got=%b exp=1", error); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL ferr_hold got=%b exp=0", cpu_hold); end
        tx_q = {8'h03, 8'h04, 8'h05};
        send_q(-1);
        @(negedge clk);
        checks++; if (wq.size() - w0 !== 1) begin errors++; $display("FAIL ferr_write_count got=%0d exp=1", wq.size() - w0); end
        checks++; if (wq.size() > w0 && wq[w0] !== 24'h0010_01)
            begin errors++; $display("FAIL ferr_write0 got=%h exp=001001", wq[w0]); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ferr_error_sticky got=%b exp=1", error); end
        tx_q = {8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h77, 8'h77};
        send_q(-1);
        @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ferr_recover_error got=%b exp=0", error); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ferr_recover_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (wq.size() - w0 !== 2 || wq[wq.size() - 1] !== 24'h0020_77)
            begin errors++; $display("FAIL ferr_recover_write got=%0d writes last=%h exp=2 writes last=002077", wq.size() - w0, wq[wq.size() - 1]); end
    endtask

    task automatic test_reset_mid;
        int w0 = wq.size();
        int d0 = done_cnt;
        tx_q = {8'hA5, 8'h03, 8'h00, 8'h00, 8'h04, 8'h10, 8'h20};
        send_q(-1);
        @(negedge clk);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rstmid_hold_before got=%b exp=1", cpu_hold); end
        rst_n = 1'b0;
        #1;
        checks++; if ({address, data_out, wrt_en, chip_select, cpu_hold, load_done, error} !== 29'b0)
            begin errors++; $display("FAIL rstmid_outputs got=%h/%h/%b exp=0000/00/00000", address, data_out, {wrt_en, chip_select, cpu_hold, load_done, error}); end
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        tx_q = {8'h30, 8'h40, 8'hA0};
        send_q(-1);
        @(negedge clk);
        checks++; if (wq.size() - w0 !== 2) begin errors++; $display("FAIL rstmid_write_count got=%0d exp=2", wq.size() - w0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_load_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rstmid_hold_after got=%b exp=0", cpu_hold); end
    endtask

    task automatic test_timeout;
        int w0 = wq.size();
        tx_q = {8'hA5, 8'h04, 8'h00, 8'h00, 8'h02, 8'h55};
        send_q(-1);
        @(negedge clk);
        checks++; if (error !== 1'b0 || cpu_hold !== 1'b1)
            begin errors++; $display("FAIL tmo_before got=err%b hold%b exp=err0 hold1", error, cpu_hold); end
        repeat (TMO + 1) @(posedge clk);
        @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error got=%b exp=1", error); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL tmo_hold got=%b exp=0", cpu_hold); end
        tx_q = {8'hAA, 8'hFF};
        send_q(-1);
        @(negedge clk);
        checks++; if (wq.size() - w0 !== 1) begin errors++; $display("FAIL tmo_write_count got=%0d exp=1", wq.size() - w0); end
    endtask

    task automatic test_strobes;
        checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width got=%0d multi-cycle strobes exp=0", wide_cnt); end
        checks++; if (cs_bad !== 0) begin errors++; $display("FAIL strobe_cs got=%0d cs/we disagreements exp=0", cs_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_wrap();
        test_zero_len();
        test_frame_err();
        test_reset_mid();
        test_timeout();
        test_strobes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_loader
`default_nettype wire

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial program loader directly upstream of the on-chip memory block; drives its address, data_in, wrt_en and chip_select write port.
- Receives a framed image over an 8N1 UART and writes it byte-by-byte into RAM.
- Holds the 6502 core off the bus (cpu_hold) for the whole load.
- Lets new programs be loaded without rebuilding the memory init file.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 8.
- TIMEOUT_CYCLES, 2**20, max idle clk cycles between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  UART receive line, asynchronous, idle high.
- address  output  16  memory write address.
- data_out  output  8  write data, connects to memory data_in.
- wrt_en  output  1  one-cycle memory write strobe.
- chip_select  output  1  asserted with wrt_en.
- cpu_hold  output  1  high while a frame is in progress; CPU bus muxes select loader, CPU held in reset.
- load_done  output  1  one-cycle pulse on successful frame end.
- error  output  1  sticky; set on checksum, framing or timeout error; cleared when next sync byte is accepted.

Behaviour:
- Reset values: address=0, data_out=0, wrt_en=0, chip_select=0, cpu_hold=0, load_done=0, error=0, FSM=IDLE. Reset mid-frame discards everything; no write after reset release until a new sync byte arrives.
- rx passes through a 2-flop synchroniser, then uart_rx.
- uart_rx:
  - Start detect is a falling edge while idle; start bit is re-checked at CLKS_PER_BIT/2 and ignored if high (glitch).
  - Samples 8 data bits LSB first at mid-bit, then the stop bit.
  - Emits byte_valid for 1 cycle with byte[7:0]; frame_err instead of byte_valid if stop bit = 0.
- Frame format: 0xA5, addr_hi, addr_lo, len_hi, len_lo, len data bytes, checksum = (sum of data bytes) mod 256.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CSUM.
  - IDLE: byte 0xA5 -> ADDR_H, clear error, set cpu_hold, clear running sum. Any other byte is ignored.
  - ADDR_H/ADDR_L: load base pointer; ADDR_L -> LEN_H.
  - LEN_H/LEN_L: load 16-bit count. LEN_L -> DATA if len != 0, else -> CSUM.
  - DATA: each byte_valid -> next cycle address=pointer, data_out=byte, wrt_en=chip_select=1 for exactly one cycle; pointer+1 (wraps 0xFFFF->0x0000); sum+=byte (8-bit wrap); count-1; count reaches 0 -> CSUM.
  - CSUM: byte == sum -> load_done pulse; else error=1. Either way -> IDLE with cpu_hold=0 on the same cycle as load_done.
- Write latency: wrt_en is asserted exactly 1 clk after the byte_valid carrying that data byte. address and data_out are registered and stable while wrt_en is high.
- wrt_en is never asserted outside DATA.
- Abort cases, all -> IDLE with error=1, cpu_hold=0, no further writes; already-written bytes stay in RAM:
  - frame_err in any non-IDLE state.
  - inter-byte timer exceeds TIMEOUT_CYCLES in any non-IDLE state; timer reloads on every byte_valid.
- frame_err in IDLE is ignored and does not set error.
- 0xA5 inside a frame is plain data, not a resync.
- len=0xFFFF with base 0x0001 writes 0x0001..0xFFFF. Addresses beyond the memory depth alias in memory; the loader does not check.

Decomposition:
- Package loader_pkg: FSM state enum loader_state_t, SYNC_BYTE=8'hA5, ADDR_W=16.
- Sub-module uart_rx (parameter CLKS_PER_BIT; ports clk, rst_n, rx_sync, byte_valid, byte, frame_err), same async active-low reset.

Test Plan:
- Frame A5 02 00 00 03 11 22 33 66 -> writes 0x11@0x0200, 0x22@0x0201, 0x33@0x0202, each wrt_en exactly 1 cycle; load_done pulse; error=0; cpu_hold high from after A5 until load_done.
- Same frame with checksum 0x67 -> same 3 writes, error=1, no load_done, cpu_hold drops.
- Frame A5 FF FF 00 02 AA BB 65 -> writes 0xAA@0xFFFF, 0xBB@0x0000 (wrap), load_done.
- Bytes 00 5A then A5 10 00 00 00 00 -> leading bytes ignored; zero-length frame, no writes, load_done.
- Stop bit forced low on 2nd data byte of len=4 frame -> 1 write, then error=1, cpu_hold=0, no more writes; next valid frame clears error.
- rst_n pulsed low mid-DATA (TIMEOUT_CYCLES=1000 bench) -> all outputs 0 immediately; remaining bytes produce no writes. Separately, stall 1001 cycles mid-frame -> error=1.
